// File: rtl/mole_field_if.sv
// rtl/mole_field_if.sv - spawner/score-side bundle for the mole_field board register
interface mole_field_if #(
    parameter int NUM_HOLES = 5,
    parameter int TIMER_W   = 8
);
    localparam int CW = $clog2(NUM_HOLES + 1);

    logic                 load;
    logic [NUM_HOLES-1:0] loadval;
    logic [TIMER_W-1:0]   lifetime;
    logic                 tick;
    logic [NUM_HOLES-1:0] button;
    logic [NUM_HOLES-1:0] board_state;
    logic                 score_trigger;
    logic [CW-1:0]        hit_count;
    logic                 miss_trigger;
    logic [CW-1:0]        miss_count;
    logic                 all_clear;
    logic                 wrong_hit;

    modport master (
        output load, loadval, lifetime, tick, button,
        input  board_state, score_trigger, hit_count, miss_trigger, miss_count, all_clear, wrong_hit
    );

    modport slave (
        input  load, loadval, lifetime, tick, button,
        output board_state, score_trigger, hit_count, miss_trigger, miss_count, all_clear, wrong_hit
    );
endinterface

// File: rtl/mole_field.sv
// rtl/mole_field.sv - per-hole mole board with lifetimes, hit/miss pulses; WRONG_HIT_EN adds wrong-hole detect
module mole_field #(
    parameter int NUM_HOLES = 5,
    parameter int TIMER_W   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mole_field_if.slave  bus
);
    localparam int CW = $clog2(NUM_HOLES + 1);

    logic [NUM_HOLES-1:0] board;
    logic [TIMER_W-1:0]   timer [NUM_HOLES];

    logic [NUM_HOLES-1:0] hit_vec;
    logic [NUM_HOLES-1:0] expire_vec;
    logic [NUM_HOLES-1:0] board_next;

    logic          score_r;
    logic [CW-1:0] hit_r;
    logic          miss_r;
    logic [CW-1:0] miss_cnt_r;
    logic          clear_r;

    function automatic logic [CW-1:0] popcount(input logic [NUM_HOLES-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // A hit masks expiry on the same hole, so a whack on the last tick still scores.
    always_comb begin
        hit_vec    = board & bus.button;
        expire_vec = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            expire_vec[i] = board[i] & ~bus.button[i] & bus.tick & (timer[i] == TIMER_W'(1));
        end
        board_next = board & ~hit_vec & ~expire_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board      <= '0;
            score_r    <= 1'b0;
            hit_r      <= '0;
            miss_r     <= 1'b0;
            miss_cnt_r <= '0;
            clear_r    <= 1'b0;
            for (int i = 0; i < NUM_HOLES; i++) begin
                timer[i] <= '0;
            end
        end else if (bus.load) begin
            board      <= bus.loadval;
            score_r    <= 1'b0;
            hit_r      <= '0;
            miss_r     <= 1'b0;
            miss_cnt_r <= '0;
            clear_r    <= 1'b0;
            for (int i = 0; i < NUM_HOLES; i++) begin
                timer[i] <= bus.loadval[i] ? bus.lifetime : '0;
            end
        end else begin
            board      <= board_next;
            score_r    <= |hit_vec;
            hit_r      <= popcount(hit_vec);
            miss_r     <= |expire_vec;
            miss_cnt_r <= popcount(expire_vec);
            clear_r    <= (board != '0) && (board_next == '0);
            // Zero timer on an active hole means immortal: only counts above 1 move.
            for (int i = 0; i < NUM_HOLES; i++) begin
                if (hit_vec[i] || expire_vec[i]) begin
                    timer[i] <= '0;
                end else if (bus.tick && board[i] && (timer[i] > TIMER_W'(1))) begin
                    timer[i] <= timer[i] - TIMER_W'(1);
                end
            end
        end
    end

`ifdef WRONG_HIT_EN
    logic wrong_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrong_r <= 1'b0;
        end else begin
            wrong_r <= !bus.load && |(bus.button & ~board);
        end
    end

    assign bus.wrong_hit = wrong_r;
`else
    assign bus.wrong_hit = 1'b0;
`endif

    assign bus.board_state   = board;
    assign bus.score_trigger = score_r;
    assign bus.hit_count     = hit_r;
    assign bus.miss_trigger  = miss_r;
    assign bus.miss_count    = miss_cnt_r;
    assign bus.all_clear     = clear_r;
endmodule

// File: tb/tb_mole_field.sv
// tb/tb_mole_field.sv - scoreboard bench for mole_field with directed vectors
module tb_mole_field;
    localparam int NH = 5;
    localparam int TW = 8;

`ifdef WRONG_HIT_EN
    localparam bit WH = 1'b1;
`else
    localparam bit WH = 1'b0;
`endif

    // {board[4:0], score, hit[2:0], miss_t, miss_c[2:0], all_clear, wrong_hit}
    typedef struct {
        string       name;
        logic [14:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    mole_field_if #(.NUM_HOLES(NH), .TIMER_W(TW)) bus ();

    mole_field #(.NUM_HOLES(NH), .TIMER_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] mk(input logic [4:0] b, input logic [2:0] h,
                                       input logic [2:0] m, input logic ac, input logic wh);
        return {b, (h != 3'd0), h, (m != 3'd0), m, ac, wh};
    endfunction

    function automatic logic [14:0] actual();
        return {bus.board_state, bus.score_trigger, bus.hit_count, bus.miss_trigger,
                bus.miss_count, bus.all_clear, bus.wrong_hit};
    endfunction

    task automatic step(input string name, input logic ld, input logic [4:0] lv,
                        input logic [7:0] lt, input logic tk, input logic [4:0] btn,
                        input logic [14:0] e);
        exp_t r;
        @(negedge clk);
        bus.load     = ld;
        bus.loadval  = lv;
        bus.lifetime = lt;
        bus.tick     = tk;
        bus.button   = btn;
        r.name = name;
        r.v    = e;
        exp_q.push_back(r);
        @(posedge clk);
    endtask

    // Monitor: outputs are always presented, so every edge with a pending expectation is compared.
    initial begin
        exp_t  r;
        logic [14:0] a;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                a = actual();
                checks++;
                if (a !== r.v) begin
                    errors++;
                    $display("FAIL %s: got b=%b s=%b h=%0d mt=%b mc=%0d ac=%b wh=%b, want b=%b s=%b h=%0d mt=%b mc=%0d ac=%b wh=%b",
                             r.name, a[14:10], a[9], a[8:6], a[5], a[4:2], a[1], a[0],
                             r.v[14:10], r.v[9], r.v[8:6], r.v[5], r.v[4:2], r.v[1], r.v[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load = 1'b0; bus.loadval = '0; bus.lifetime = '0; bus.tick = 1'b0; bus.button = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        step("reset_state", 0, 5'b00000, 8'd0, 0, 5'b00000, mk(5'b00000, 0, 0, 0, 0));

        step("t1_load",  1, 5'b10101, 8'd3, 0, 5'b00000, mk(5'b10101, 0, 0, 0, 0));
        step("t1_hit",   0, 5'b00000, 8'd0, 0, 5'b00101, mk(5'b10000, 2, 0, 0, 0));
        step("t1_idle",  0, 5'b00000, 8'd0, 0, 5'b00000, mk(5'b10000, 0, 0, 0, 0));

        step("t2_load",  1, 5'b00011, 8'd2, 0, 5'b00000, mk(5'b00011, 0, 0, 0, 0));
        step("t2_tick1", 0, 5'b00000, 8'd0, 1, 5'b00000, mk(5'b00011, 0, 0, 0, 0));
        step("t2_tick2", 0, 5'b00000, 8'd0, 1, 5'b00000, mk(5'b00000, 0, 2, 1, 0));
        step("t2_idle",  0, 5'b00000, 8'd0, 0, 5'b00000, mk(5'b00000, 0, 0, 0, 0));

        step("t3_load",  1, 5'b00001, 8'd1, 0, 5'b00000, mk(5'b00001, 0, 0, 0, 0));
        step("t3_hit_vs_expire", 0, 5'b00000, 8'd0, 1, 5'b00001, mk(5'b00000, 1, 0, 1, 0));

        step("t4_load",  1, 5'b11111, 8'd0, 0, 5'b00000, mk(5'b11111, 0, 0, 0, 0));
        for (int i = 0; i < 300; i++) begin
            step("t4_infinite_tick", 0, 5'b00000, 8'd0, 1, 5'b00000, mk(5'b11111, 0, 0, 0, 0));
        end
        step("t4_all_hit", 0, 5'b00000, 8'd0, 0, 5'b11111, mk(5'b00000, 5, 0, 1, 0));

        step("t5_load",  1, 5'b11111, 8'd5, 0, 5'b00000, mk(5'b11111, 0, 0, 0, 0));
        step("t5_load_beats_hit", 1, 5'b01010, 8'd5, 0, 5'b11111, mk(5'b01010, 0, 0, 0, 0));
        step("t5_tick",  0, 5'b00000, 8'd0, 1, 5'b00000, mk(5'b01010, 0, 0, 0, 0));

        @(negedge clk);
        bus.tick = 1'b0; bus.button = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (actual() !== mk(5'b00000, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL async_reset: got %b, want %b", actual(), mk(5'b00000, 0, 0, 0, 0));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step("t5_after_reset", 0, 5'b00000, 8'd0, 1, 5'b00000, mk(5'b00000, 0, 0, 0, 0));

        step("t6_load",  1, 5'b00001, 8'd0, 0, 5'b00000, mk(5'b00001, 0, 0, 0, 0));
        step("t6_wrong_and_hit", 0, 5'b00000, 8'd0, 0, 5'b00011, mk(5'b00000, 1, 0, 1, WH));
        step("t6_held_on_cleared", 0, 5'b00000, 8'd0, 0, 5'b00001, mk(5'b00000, 0, 0, 0, WH));
        step("t6_idle",  0, 5'b00000, 8'd0, 0, 5'b00000, mk(5'b00000, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mole_field.md
Name: mole_field

Overview:
Parametrised successor to the five-hole board register. It holds NUM_HOLES mole-active bits, each with its own lifetime countdown. Each cycle it reports hits (active mole whacked) and misses (mole expired unhit). It sits between the mole spawner, which drives load/loadval/lifetime, and the score/round logic, which consumes the pulses and counts.

Parameters:
NUM_HOLES, 5, number of holes/moles (1..32)
TIMER_W, 8, width of per-mole lifetime counter in tick units

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
load  input  1  active-high; replace board with loadval this cycle
loadval  input  NUM_HOLES  active-high mole pattern to load
lifetime  input  TIMER_W  lifetime in ticks given to every loaded mole; 0 = never expires
tick  input  1  active-high timebase strobe; advances lifetime counters
button  input  NUM_HOLES  active-high per-hole whack pulses
board_state  output  NUM_HOLES  active-high current moles
score_trigger  output  1  pulse: at least one hit this cycle
hit_count  output  CW  number of holes hit this cycle, CW = $clog2(NUM_HOLES+1)
miss_trigger  output  1  pulse: at least one mole expired this cycle
miss_count  output  CW  number of moles expired this cycle
all_clear  output  1  pulse: board went from non-empty to empty by hit/expiry
wrong_hit  output  1  pulse: button on an inactive hole (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): board_state=0, all timers=0, all pulses=0, all counts=0. Reset mid-round drops all moles with no miss reported.
- All outputs are registered. A pulse or count refers to events sampled on the previous clk edge, so latency is 1 cycle. Pulses and counts are 0 in any cycle with no event.
- Priority per cycle: load > hit > expiry.
- Load: board_state<=loadval. timer[i]<=lifetime where loadval[i]=1, else 0. Hits and expiries are ignored in a load cycle, so all pulses and counts are 0 and all_clear=0.
- Hit on hole i: board_state[i]=1 and button[i]=1. Clear bit i and its timer. Per-hole, independent of other holes.
- Expiry on hole i: board_state[i]=1, no hit on i, tick=1, timer[i]==1. Clear bit i. Counts as a miss.
- Countdown: on tick, every active hole with timer>1 decrements by 1. timer==0 on an active hole means infinite; it never decrements or expires.
- Same hole hit and expiring in the same cycle: the hit wins and no miss is counted.
- hit_count/miss_count: popcount of hit/expiry vectors. score_trigger = (hit_count!=0), miss_trigger = (miss_count!=0).
- all_clear: set when board_state was non-zero and becomes zero through hits and/or expiries. Never asserted on load or reset.
- button is level-sampled each cycle. The caller supplies single-cycle pulses; a held button on an already-cleared hole does nothing.
- Generation for any NUM_HOLES: counts must not overflow at all-holes-hit (NUM_HOLES=5 gives CW=3, max 5).

Optional Feature:
Macro WRONG_HIT_EN.
- Defined: in a non-load cycle, wrong_hit pulses (registered, 1-cycle latency) when any button[i]=1 with board_state[i]=0. This is independent of hits in other holes in the same cycle.
- Undefined: wrong_hit is tied to 0 and no detection logic is built.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then load loadval=5'b10101, lifetime=3; button=5'b00101 one cycle -> next cycle board_state=5'b10000, score_trigger=1, hit_count=2, miss_trigger=0.
- Load 5'b00011, lifetime=2; 2 ticks, no buttons -> after 2nd tick board_state=0, miss_trigger=1, miss_count=2, all_clear=1.
- Load 5'b00001, lifetime=1; tick and button[0] same cycle -> hit_count=1, miss_count=0, all_clear=1.
- Load 5'b11111, lifetime=0; 300 ticks -> board_state stays 5'b11111, no misses. Then button=5'b11111 -> hit_count=5, all_clear=1.
- Load asserted while button=5'b11111 on a full board -> board_state=loadval, all pulses 0. Assert rst_n low mid-countdown -> board_state=0 immediately (asynchronous), no miss.
- WRONG_HIT_EN defined: board 5'b00001, button=5'b00011 -> hit_count=1, wrong_hit=1. Undefined: same stimulus -> wrong_hit=0.
